// File: rtl/axi_rd_req_queue_if.sv
// Bundles the AR request channel, the read-engine command channel, the R-channel
// bookkeeping signals and the queue status flags for axi_rd_req_queue.
interface axi_rd_req_queue_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 6,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              s_arvalid;
  logic              s_arready;
  logic [ADDR_W-1:0] s_araddr;
  logic [ID_W-1:0]   s_arid;
  logic [7:0]        s_arlen;
  logic [2:0]        s_arsize;
  logic [1:0]        s_arburst;
  logic [2:0]        s_arprot;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ID_W-1:0]   cmd_id;
  logic [7:0]        cmd_len;
  logic [2:0]        cmd_size;
  logic [1:0]        cmd_burst;
  logic [2:0]        cmd_prot;

  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_done;

  logic [CNT_W-1:0]  pend_level;
  logic [CNT_W-1:0]  occ_level;
  logic              almost_full;
  logic              err_underflow;

  modport slave (
    input  s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_arprot,
    output s_arready,
    output cmd_valid, cmd_addr, cmd_id, cmd_len, cmd_size, cmd_burst, cmd_prot,
    input  cmd_ready,
    output rsp_valid, rsp_id,
    input  rsp_done,
    output pend_level, occ_level, almost_full, err_underflow
  );

  modport master (
    output s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_arprot,
    input  s_arready,
    input  cmd_valid, cmd_addr, cmd_id, cmd_len, cmd_size, cmd_burst, cmd_prot,
    output cmd_ready,
    input  rsp_valid, rsp_id,
    output rsp_done,
    input  pend_level, occ_level, almost_full, err_underflow
  );
endinterface

// File: rtl/axi_rd_req_queue.sv
// In-order AXI read-request queue: one write pointer, plus separate issue and
// response read pointers over the same entry storage.
module axi_rd_req_queue #(
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 6,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  axi_rd_req_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [2:0]        prot;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           wr_entry;
  entry_t           iss_entry;
  entry_t           rsp_entry;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] iss_ptr;
  logic [PTR_W-1:0] rsp_ptr;
  logic [CNT_W-1:0] pend_cnt;
  logic [CNT_W-1:0] occ_cnt;
  logic [CNT_W-1:0] inflight_cnt;
  logic             err_q;

  logic             full;
  logic             ar_rdy;
  logic             cmd_vld;
  logic             rsp_vld;
  logic             acc;
  logic             iss;
  logic             cpl;

  // Handshake decode; every output is gated by reset so nothing leaks while it is high.
  assign inflight_cnt = occ_cnt - pend_cnt;
  assign full         = (occ_cnt == CNT_W'(DEPTH));
  assign ar_rdy       = ~reset & ~full;
  assign cmd_vld      = ~reset & (pend_cnt != '0);
  assign rsp_vld      = ~reset & (inflight_cnt != '0);
  assign acc          = bus.s_arvalid & ar_rdy;
  assign iss          = cmd_vld & bus.cmd_ready;
  assign cpl          = rsp_vld & bus.rsp_done;

  assign wr_entry.addr  = bus.s_araddr;
  assign wr_entry.id    = bus.s_arid;
  assign wr_entry.len   = bus.s_arlen;
  assign wr_entry.size  = bus.s_arsize;
  assign wr_entry.burst = bus.s_arburst;
  assign wr_entry.prot  = bus.s_arprot;

  // Storage holds data only, so it is written without reset.
  always_ff @(posedge clk) begin
    if (acc) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      iss_ptr  <= '0;
      rsp_ptr  <= '0;
      pend_cnt <= '0;
      occ_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (iss) begin
        iss_ptr <= iss_ptr + PTR_W'(1);
      end
      if (cpl) begin
        rsp_ptr <= rsp_ptr + PTR_W'(1);
      end
      pend_cnt <= pend_cnt + CNT_W'(acc) - CNT_W'(iss);
      occ_cnt  <= occ_cnt + CNT_W'(acc) - CNT_W'(cpl);
      if (bus.rsp_done && !rsp_vld) begin
        err_q <= 1'b1;
      end
    end
  end

  // Read side: both ports look at registered pointers only, so there is no bypass.
  assign iss_entry = mem[iss_ptr];
  assign rsp_entry = mem[rsp_ptr];

  assign bus.s_arready     = ar_rdy;
  assign bus.cmd_valid     = cmd_vld;
  assign bus.cmd_addr      = cmd_vld ? iss_entry.addr  : '0;
  assign bus.cmd_id        = cmd_vld ? iss_entry.id    : '0;
  assign bus.cmd_len       = cmd_vld ? iss_entry.len   : '0;
  assign bus.cmd_size      = cmd_vld ? iss_entry.size  : '0;
  assign bus.cmd_burst     = cmd_vld ? iss_entry.burst : '0;
  assign bus.cmd_prot      = cmd_vld ? iss_entry.prot  : '0;
  assign bus.rsp_valid     = rsp_vld;
  assign bus.rsp_id        = rsp_vld ? rsp_entry.id    : '0;
  assign bus.pend_level    = reset ? '0 : pend_cnt;
  assign bus.occ_level     = reset ? '0 : occ_cnt;
  assign bus.almost_full   = ~reset & (occ_cnt >= CNT_W'(AFULL_LVL));
  assign bus.err_underflow = ~reset & err_q;
endmodule
